// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the unified instruction/data memory port.
package riscv_mem_pkg;

    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_TIMEOUT_CYC = 255;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DATA       = 3'd1,
        FETCH      = 3'd2,
        FETCH_DROP = 3'd3,
        ERR        = 3'd4
    } arb_state_e;

    // True for every state in which a transaction is outstanding on the memory port.
    function automatic logic state_drives_mem(input arb_state_e st);
        logic busy;
        case (st)
            DATA, FETCH, FETCH_DROP: busy = 1'b1;
            default:                 busy = 1'b0;
        endcase
        return busy;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// 8-bit wait counter for the memory port. tc fires combinationally in the
// cycle that would bring the count to LIMIT, so the caller can abandon the
// transaction on that same clock edge.
module mem_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] cnt_r;

    assign tc = en & (cnt_r == LAST);

    // Count stalled memory cycles; a fresh grant restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (en) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch (IF) and load/store (MEM).
// Data side wins ties; a fetch squashed by a taken branch still completes on
// the bus but its response is discarded. A hung bus latches a sticky error.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);

    arb_state_e        state_r;
    arb_state_e        next_state_s;
    logic              arb_s;
    logic              mask_dm_s;
    logic              mask_if_s;
    logic              grant_dm_s;
    logic              grant_if_s;
    logic              dm_done_s;
    logic              if_done_s;
    logic              tmo_tc_s;
    logic              mem_req_nxt_s;
    logic              mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_nxt_s;
    logic [DATA_W-1:0] mem_wdata_nxt_s;
    logic              if_valid_nxt_s;
    logic [DATA_W-1:0] if_rdata_nxt_s;
    logic              dm_valid_nxt_s;
    logic [DATA_W-1:0] dm_rdata_nxt_s;
    logic              timeout_err_nxt_s;

    mem_timeout_counter #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_dm_s | grant_if_s),
        .en    (mem_req & ~mem_ack),
        .tc    (tmo_tc_s)
    );

    // Stalls hold a stage until its own completion pulse is visible.
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = dm_req & ~dm_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: completion, timeout, squash and re-arbitration.
    always_comb begin
        next_state_s = state_r;
        arb_s        = 1'b0;
        mask_dm_s    = 1'b0;
        mask_if_s    = 1'b0;
        dm_done_s    = 1'b0;
        if_done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                arb_s = 1'b1;
            end
            DATA: begin
                if (mem_ack) begin
                    dm_done_s = 1'b1;
                    arb_s     = 1'b1;
                    mask_dm_s = 1'b1;
                end else if (tmo_tc_s) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = DATA;
                end
            end
            FETCH: begin
                if (mem_ack) begin
                    if_done_s = ~flush;
                    arb_s     = 1'b1;
                    mask_if_s = 1'b1;
                end else if (tmo_tc_s) begin
                    next_state_s = ERR;
                end else if (flush) begin
                    next_state_s = FETCH_DROP;
                end else begin
                    next_state_s = FETCH;
                end
            end
            FETCH_DROP: begin
                if (mem_ack) begin
                    arb_s     = 1'b1;
                    mask_if_s = 1'b1;
                end else if (tmo_tc_s) begin
                    next_state_s = ERR;
                end else begin
                    next_state_s = FETCH_DROP;
                end
            end
            ERR: begin
                next_state_s = ERR;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase

        // The requester that just completed is masked so it is not re-served
        // on its own stale request in the ack cycle.
        grant_dm_s = arb_s & dm_req & ~mask_dm_s;
        grant_if_s = arb_s & if_req & ~mask_if_s & ~grant_dm_s;
        if (grant_dm_s) begin
            next_state_s = DATA;
        end else if (grant_if_s) begin
            next_state_s = FETCH;
        end else if (arb_s) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // Output logic: next values of the bus and response registers.
    always_comb begin
        mem_req_nxt_s   = state_drives_mem(next_state_s);
        mem_we_nxt_s    = mem_we;
        mem_addr_nxt_s  = mem_addr;
        mem_wdata_nxt_s = mem_wdata;
        if (grant_dm_s) begin
            mem_we_nxt_s    = dm_we;
            mem_addr_nxt_s  = dm_addr;
            mem_wdata_nxt_s = dm_wdata;
        end else if (grant_if_s) begin
            mem_we_nxt_s    = 1'b0;
            mem_addr_nxt_s  = if_addr;
        end else begin
            mem_we_nxt_s    = mem_we;
        end

        dm_valid_nxt_s = dm_done_s;
        if (dm_done_s) begin
            dm_rdata_nxt_s = mem_we ? {DATA_W{1'b0}} : mem_rdata;
        end else begin
            dm_rdata_nxt_s = dm_rdata;
        end

        if_valid_nxt_s = if_done_s;
        if (if_done_s) begin
            if_rdata_nxt_s = mem_rdata;
        end else begin
            if_rdata_nxt_s = if_rdata;
        end

        timeout_err_nxt_s = timeout_err | (next_state_s == ERR);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            if_valid    <= 1'b0;
            if_rdata    <= {DATA_W{1'b0}};
            dm_valid    <= 1'b0;
            dm_rdata    <= {DATA_W{1'b0}};
            timeout_err <= 1'b0;
        end else begin
            mem_req     <= mem_req_nxt_s;
            mem_we      <= mem_we_nxt_s;
            mem_addr    <= mem_addr_nxt_s;
            mem_wdata   <= mem_wdata_nxt_s;
            if_valid    <= if_valid_nxt_s;
            if_rdata    <= if_rdata_nxt_s;
            dm_valid    <= dm_valid_nxt_s;
            dm_rdata    <= dm_rdata_nxt_s;
            timeout_err <= timeout_err_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          flush = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          stall_if;
    logic          stall_mem;
    logic          timeout_err;

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .dm_req      (dm_req),
        .dm_we       (dm_we),
        .dm_addr     (dm_addr),
        .dm_wdata    (dm_wdata),
        .dm_rdata    (dm_rdata),
        .dm_valid    (dm_valid),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .stall_if    (stall_if),
        .stall_mem   (stall_mem),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one outstanding transaction) --------
    typedef enum int {OWN_NONE, OWN_DM, OWN_IF} owner_t;

    owner_t      m_owner = OWN_NONE;
    bit          m_squash = 1'b0;
    bit          m_err = 1'b0;
    int          m_wait = 0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    logic        e_if_valid = 1'b0;
    logic        e_dm_valid = 1'b0;
    logic [31:0] e_if_rdata = 32'h0;
    logic [31:0] e_dm_rdata = 32'h0;

    task automatic model_grant(input owner_t excl);
        if (dm_req && excl != OWN_DM) begin
            m_owner = OWN_DM; m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
            m_wait = 0; m_squash = 1'b0;
        end else if (if_req && excl != OWN_IF) begin
            m_owner = OWN_IF; m_we = 1'b0; m_addr = if_addr;
            m_wait = 0; m_squash = 1'b0;
        end else begin
            m_owner = OWN_NONE;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = OWN_NONE; m_squash = 1'b0; m_err = 1'b0; m_wait = 0;
                m_we = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
                e_if_valid = 1'b0; e_dm_valid = 1'b0;
                e_if_rdata = 32'h0; e_dm_rdata = 32'h0;
            end else begin
                e_if_valid = 1'b0;
                e_dm_valid = 1'b0;
                if (m_err) begin
                    m_owner = OWN_NONE;
                end else if (m_owner == OWN_NONE) begin
                    model_grant(OWN_NONE);
                end else if (mem_ack) begin
                    if (m_owner == OWN_DM) begin
                        e_dm_valid = 1'b1;
                        e_dm_rdata = m_we ? 32'h0 : mem_rdata;
                    end else if (!m_squash && !flush) begin
                        e_if_valid = 1'b1;
                        e_if_rdata = mem_rdata;
                    end
                    model_grant(m_owner);
                end else begin
                    m_wait++;
                    if (m_wait >= TO) begin
                        m_err = 1'b1;
                        m_owner = OWN_NONE;
                    end else if (m_owner == OWN_IF && flush) begin
                        m_squash = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- every-cycle comparison against the model -------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("mem_req", mem_req, (m_owner != OWN_NONE) && !m_err);
                if ((m_owner != OWN_NONE) && !m_err) begin
                    chk("mem_we", mem_we, m_we);
                    chk("mem_addr", mem_addr, m_addr);
                    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                end
                chk("if_valid", if_valid, e_if_valid);
                if (e_if_valid) chk("if_rdata", if_rdata, e_if_rdata);
                chk("dm_valid", dm_valid, e_dm_valid);
                if (e_dm_valid) chk("dm_rdata", dm_rdata, e_dm_rdata);
                chk("stall_if", stall_if, if_req & ~e_if_valid);
                chk("stall_mem", stall_mem, dm_req & ~e_dm_valid);
                chk("timeout_err", timeout_err, m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus with literal expectations ----------
    initial begin
        repeat (2) tick();
        chk("rst_mem_req", mem_req, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_err", timeout_err, 32'h0);
        rst_n = 1'b1;
        tick();

        // Fetch alone, ack in the third bus cycle.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        tick();
        chk("f1_mem_req", mem_req, 32'h1);
        chk("f1_mem_addr", mem_addr, 32'h0000_0010);
        chk("f1_mem_we", mem_we, 32'h0);
        chk("f1_stall_if", stall_if, 32'h1);
        tick();
        chk("f1_stall_if2", stall_if, 32'h1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        tick();
        chk("f1_if_valid", if_valid, 32'h1);
        chk("f1_if_rdata", if_rdata, 32'h0050_0093);
        mem_ack = 1'b0; if_req = 1'b0;
        tick();
        chk("f1_pulse_end", if_valid, 32'h0);

        // Simultaneous store and fetch: store first, fetch in the ack cycle.
        if_req = 1'b1; if_addr = 32'h0000_0014;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
        tick();
        chk("s2_mem_we", mem_we, 32'h1);
        chk("s2_mem_addr", mem_addr, 32'h0000_0100);
        chk("s2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("s2_dm_valid", dm_valid, 32'h1);
        chk("s2_dm_rdata", dm_rdata, 32'h0);
        chk("s2_fetch_addr", mem_addr, 32'h0000_0014);
        chk("s2_fetch_we", mem_we, 32'h0);
        dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 32'h0000_0013;
        tick();
        chk("s2_if_rdata", if_rdata, 32'h0000_0013);
        if_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Load with ack one cycle after mem_req; flush during DATA is ignored.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; flush = 1'b1;
        tick();
        chk("l3_early_valid", dm_valid, 32'h0);
        chk("l3_mem_addr", mem_addr, 32'h0000_0200);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        chk("l3_dm_valid", dm_valid, 32'h1);
        chk("l3_dm_rdata", dm_rdata, 32'h1234_5678);
        dm_req = 1'b0; flush = 1'b0;
        tick();
        chk("idle_ack_ignored", dm_valid | if_valid | mem_req, 32'h0);
        mem_ack = 1'b0;
        tick();

        // Flush while fetch pending, then the redirected fetch.
        if_req = 1'b1; if_addr = 32'h0000_0020;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; if_addr = 32'h0000_0040;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        tick();
        chk("d4_no_valid", if_valid, 32'h0);
        mem_ack = 1'b0;
        tick();
        chk("d4_new_addr", mem_addr, 32'h0000_0040);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0513;
        tick();
        chk("d4_if_rdata", if_rdata, 32'h0000_0513);
        mem_ack = 1'b0; if_addr = 32'h0000_0044;
        tick();
        // Flush coincident with the fetch ack.
        tick();
        mem_ack = 1'b1; flush = 1'b1;
        tick();
        chk("d4b_no_valid", if_valid, 32'h0);
        mem_ack = 1'b0; flush = 1'b0; if_req = 1'b0;
        tick();

        // Asynchronous reset in the middle of a load.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
        tick();
        chk("r5_mem_req", mem_req, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("r5_async_req", mem_req, 32'h0);
        mem_ack = 1'b1;
        tick();
        rst_n = 1'b1; dm_req = 1'b0; mem_ack = 1'b0;
        tick();
        chk("r5_no_valid", dm_valid, 32'h0);
        tick();

        // Timeout: four unanswered cycles, then absorbing error.
        if_req = 1'b1; if_addr = 32'h0000_0050;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_req_held", mem_req, 32'h1);
        end
        tick();
        chk("t6_req_drop", mem_req, 32'h0);
        chk("t6_err", timeout_err, 32'h1);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0400;
        for (int i = 0; i < 3; i++) begin
            mem_ack = (i == 1);
            tick();
            chk("t6_no_grant", mem_req, 32'h0);
            chk("t6_err_sticky", timeout_err, 32'h1);
        end
        mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_err", timeout_err, 32'h0);
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_after_rst", mem_req | timeout_err, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
